// File: rtl/dispenser_pkg.sv
// Shared types and defaults for the change dispenser: FSM encoding, parameter
// defaults and the timer-width helper.
package dispenser_pkg;

  localparam int unsigned PulseWDef = 4;
  localparam int unsigned GapWDef   = 2;
  localparam int unsigned CntWDef   = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSodaOn,
    StC2On,
    StC1On,
    StGap
  } state_e;

  // Wide enough for max(pulse, gap) - 1; never narrower than one bit.
  function automatic int unsigned tmr_width(int unsigned pulse_w, int unsigned gap_w);
    int unsigned m;
    m = (pulse_w > gap_w) ? pulse_w : gap_w;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating pending-request counter: adds 0..3 and subtracts 0..1 per cycle,
// applying the net change and flagging when the result had to be clamped.
module pend_counter
  import dispenser_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             sat_hit
);

  localparam logic [CNT_W+1:0] Max = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W+1:0] net;

  always_comb begin
    // dec is only issued on a nonzero count, so net never underflows.
    net     = {2'b00, count_q} + {{CNT_W{1'b0}}, inc} - {{(CNT_W + 1){1'b0}}, dec};
    count_d = net[CNT_W-1:0];
    sat_hit = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (net > Max) begin
      count_d = Max[CNT_W-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign nonzero = |count_q;

endmodule

// File: rtl/change_dispenser.sv
// Queues soda / coin requests from the vending DFA and plays them out as
// fixed-width actuator pulses separated by a fixed gap, soda > c2 > c1.
module change_dispenser
  import dispenser_pkg::*;
#(
  parameter int unsigned PULSE_W = PulseWDef,
  parameter int unsigned GAP_W   = GapWDef,
  parameter int unsigned CNT_W   = CntWDef
) (
  input  logic clk,
  input  logic rst,
  input  logic soda,
  input  logic out1,
  input  logic out2,
  input  logic out2x2,
  input  logic hold,
  input  logic clr_err,
  output logic soda_drop,
  output logic eject1,
  output logic eject2,
  output logic busy,
  output logic overflow
);

  localparam int unsigned     TmrW    = tmr_width(PULSE_W, GAP_W);
  localparam logic [TmrW-1:0] PulseLd = TmrW'(PULSE_W - 1);
  localparam logic [TmrW-1:0] GapLd   = TmrW'(GAP_W - 1);

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              overflow_q, overflow_d;
  logic              dec_soda, dec_c1, dec_c2;
  logic              nz_soda, nz_c1, nz_c2;
  logic              sat_soda, sat_c1, sat_c2;
  logic [CNT_W-1:0]  cnt_soda, cnt_c1, cnt_c2;
  logic [1:0]        inc_c2;

  assign inc_c2 = {1'b0, out2} + {out2x2, 1'b0};

  pend_counter #(.CNT_W(CNT_W)) u_cnt_soda (
    .clk     (clk),
    .rst     (rst),
    .inc     ({1'b0, soda}),
    .dec     (dec_soda),
    .clr     (1'b0),
    .count   (cnt_soda),
    .nonzero (nz_soda),
    .sat_hit (sat_soda)
  );

  pend_counter #(.CNT_W(CNT_W)) u_cnt_c1 (
    .clk     (clk),
    .rst     (rst),
    .inc     ({1'b0, out1}),
    .dec     (dec_c1),
    .clr     (1'b0),
    .count   (cnt_c1),
    .nonzero (nz_c1),
    .sat_hit (sat_c1)
  );

  pend_counter #(.CNT_W(CNT_W)) u_cnt_c2 (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc_c2),
    .dec     (dec_c2),
    .clr     (1'b0),
    .count   (cnt_c2),
    .nonzero (nz_c2),
    .sat_hit (sat_c2)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    dec_soda = 1'b0;
    dec_c1   = 1'b0;
    dec_c2   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!hold) begin
          if (nz_soda) begin
            dec_soda = 1'b1;
            tmr_d    = PulseLd;
            state_d  = StSodaOn;
          end else if (nz_c2) begin
            dec_c2  = 1'b1;
            tmr_d   = PulseLd;
            state_d = StC2On;
          end else if (nz_c1) begin
            dec_c1  = 1'b1;
            tmr_d   = PulseLd;
            state_d = StC1On;
          end
        end
      end
      StSodaOn, StC2On, StC1On: begin
        if (tmr_q == '0) begin
          tmr_d   = GapLd;
          state_d = StGap;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StGap: begin
        if (tmr_q == '0) begin
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A fresh saturation wins over a simultaneous clear.
  assign overflow_d = sat_soda | sat_c1 | sat_c2 | (overflow_q & ~clr_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      overflow_q <= overflow_d;
    end
  end

  assign soda_drop = (state_q == StSodaOn);
  assign eject2    = (state_q == StC2On);
  assign eject1    = (state_q == StC1On);
  assign overflow  = overflow_q;
  assign busy      = (state_q != StIdle) | (|cnt_soda) | (|cnt_c1) | (|cnt_c2);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a negedge monitor reconstructs actuator
// pulses and scores them against an expected-pulse queue filled by the stimulus.
module tb_change_dispenser;

  localparam int PW = 4;

  // Pulse kinds as {soda_drop, eject2, eject1}.
  localparam logic [2:0] KSoda = 3'b100;
  localparam logic [2:0] KC2   = 3'b010;
  localparam logic [2:0] KC1   = 3'b001;

  logic clk = 1'b0;
  logic rst, soda, out1, out2, out2x2, hold, clr_err;
  logic soda_drop, eject1, eject2, busy, overflow;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic [2:0] exp_q[$];
  int starts[$];

  change_dispenser dut (
    .clk       (clk),
    .rst       (rst),
    .soda      (soda),
    .out1      (out1),
    .out2      (out2),
    .out2x2    (out2x2),
    .hold      (hold),
    .clr_err   (clr_err),
    .soda_drop (soda_drop),
    .eject1    (eject1),
    .eject2    (eject2),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < budget) begin
      step();
      i++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  // Pulse monitor / scoreboard consumer.
  initial begin
    logic [2:0] cur, obs, e;
    int width;
    cur   = '0;
    width = 0;
    forever begin
      @(negedge clk);
      obs = {soda_drop, eject2, eject1};
      if (rst) begin
        cur   = '0;
        width = 0;
      end else begin
        check("onehot", {31'd0, $onehot0(obs)}, 1);
        if (obs != cur) begin
          if (cur != '0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_pulse", {29'd0, cur}, 0);
            end else begin
              e = exp_q.pop_front();
              check("pulse_kind", {29'd0, cur}, {29'd0, e});
            end
            check("pulse_width", width, PW);
          end
          cur   = obs;
          width = (obs != '0) ? 1 : 0;
          if (obs != '0) starts.push_back(cyc);
        end else if (cur != '0) begin
          width++;
        end
      end
    end
  end

  initial begin
    int s0;
    int i;
    rst = 1'b1; soda = 1'b0; out1 = 1'b0; out2 = 1'b0; out2x2 = 1'b0;
    hold = 1'b0; clr_err = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);

    // 1: reset mid-sim with no traffic, then idle
    #1 rst = 1'b1;
    #1;
    check("t1_rst_out", {28'd0, soda_drop, eject1, eject2, busy}, 0);
    check("t1_rst_ovf", {31'd0, overflow}, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t1_idle_out", {28'd0, soda_drop, eject1, eject2, busy}, 0);
    end

    // 2: single soda, latency and timing
    exp_q.push_back(KSoda);
    soda = 1'b1;
    step();
    soda = 1'b0;
    check("t2_edge_k_low", {31'd0, soda_drop}, 0);
    check("t2_edge_k_busy", {31'd0, busy}, 1);
    step();
    check("t2_rise", {31'd0, soda_drop}, 1);
    step(3);
    check("t2_still_high", {31'd0, soda_drop}, 1);
    step();
    check("t2_gap_low", {31'd0, soda_drop}, 0);
    check("t2_gap_busy1", {31'd0, busy}, 1);
    step();
    check("t2_gap_busy2", {31'd0, busy}, 1);
    step();
    check("t2_busy_fall", {31'd0, busy}, 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: soda + out2x2 together
    s0 = starts.size();
    exp_q.push_back(KSoda);
    exp_q.push_back(KC2);
    exp_q.push_back(KC2);
    soda = 1'b1; out2x2 = 1'b1;
    step();
    soda = 1'b0; out2x2 = 1'b0;
    wait_idle(60, "t3");
    check("t3_npulses", starts.size() - s0, 3);
    if (starts.size() - s0 == 3) begin
      check("t3_space1", starts[s0+1] - starts[s0], 7);
      check("t3_space2", starts[s0+2] - starts[s0+1], 7);
    end
    check("t3_cnt_c2", {29'd0, dut.u_cnt_c2.count}, 0);
    check("t3_sb_empty", exp_q.size(), 0);

    // 4: saturation under hold, drain, clear
    hold = 1'b1; out1 = 1'b1;
    step(7);
    check("t4_no_ovf_at7", {31'd0, overflow}, 0);
    step();
    out1 = 1'b0;
    check("t4_ovf_at8", {31'd0, overflow}, 1);
    check("t4_cnt_c1", {29'd0, dut.u_cnt_c1.count}, 7);
    check("t4_held", {31'd0, eject1}, 0);
    repeat (7) exp_q.push_back(KC1);
    hold = 1'b0;
    wait_idle(120, "t4");
    check("t4_ovf_sticky", {31'd0, overflow}, 1);
    check("t4_sb_empty", exp_q.size(), 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t4_ovf_clr", {31'd0, overflow}, 0);

    // 5: async reset while eject2 is high
    hold = 1'b1; out2x2 = 1'b1;
    step();
    out2x2 = 1'b0; out2 = 1'b1;
    step();
    out2 = 1'b0;
    check("t5_cnt_c2_3", {29'd0, dut.u_cnt_c2.count}, 3);
    hold = 1'b0;
    i = 0;
    while (eject2 !== 1'b1 && i < 10) begin
      step();
      i++;
    end
    check("t5_eject2_up", {31'd0, eject2}, 1);
    check("t5_cnt_c2_2", {29'd0, dut.u_cnt_c2.count}, 2);
    #2 rst = 1'b1;
    #1;
    check("t5_async_fall", {31'd0, eject2}, 0);
    check("t5_async_busy", {31'd0, busy}, 0);
    step();
    rst = 1'b0;
    step(20);
    check("t5_no_replay", {30'd0, eject2, busy}, 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // 6: increment and decrement on the same edge
    exp_q.push_back(KC1);
    exp_q.push_back(KC1);
    out1 = 1'b1;
    step();
    check("t6_cnt_1", {29'd0, dut.u_cnt_c1.count}, 1);
    step();
    out1 = 1'b0;
    check("t6_cnt_net", {29'd0, dut.u_cnt_c1.count}, 1);
    check("t6_eject1_on", {31'd0, eject1}, 1);
    wait_idle(60, "t6");
    check("t6_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending-machine DFA.
- Consumes the DFA's single-cycle result pulses (soda, out1, out2, out2x2), queues them as pending counts, and drives the physical actuators.
- Actuators are a soda-drop solenoid and two coin ejectors (value 1 and value 2). Each actuator pulse has a fixed width and is followed by a fixed gap.
- An actuator-ready hold input stalls new pulses without losing any requests.

Parameters:
- PULSE_W, 4, actuator high time in clk cycles (≥1).
- GAP_W, 2, mandatory low time after each pulse in clk cycles (≥1).
- CNT_W, 3, width of each pending counter; max pending per kind = 2^CNT_W−1 (7).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- soda  in  1  from DFA: deliver one soda (single-cycle pulse).
- out1  in  1  from DFA: return one 1-coin.
- out2  in  1  from DFA: return one 2-coin.
- out2x2  in  1  from DFA: return two 2-coins.
- hold  in  1  actuators not ready; blocks start of new pulse.
- clr_err  in  1  synchronous clear of overflow.
- soda_drop  out  1  soda solenoid drive.
- eject1  out  1  1-coin ejector drive.
- eject2  out  1  2-coin ejector drive.
- busy  out  1  any pending count nonzero or FSM not IDLE.
- overflow  out  1  sticky: a request was dropped on saturation.

Behaviour:
- Reset (async): FSM→IDLE; all counters, timer and overflow→0; soda_drop, eject1, eject2 and busy→0 immediately.
  - Reset mid-pulse truncates the pulse.
  - Nothing is replayed after reset deasserts.
- Pending counters: cnt_soda, cnt_c1, cnt_c2 are CNT_W-bit and saturating.
  - soda: cnt_soda +1. out1: cnt_c1 +1. out2: cnt_c2 +1. out2x2: cnt_c2 +2.
  - out2 and out2x2 in the same cycle: cnt_c2 +3.
- Saturation: if an increment would exceed the maximum, the counter clamps at the maximum and overflow sets.
  - overflow holds until clr_err or rst.
  - clr_err and a new overflow in the same cycle: overflow stays 1.
- Simultaneous increment and decrement on one counter: net result is applied (e.g. 1, +1, −1 → 1). Saturation is checked on the net value.
- FSM states: IDLE, SODA_ON, C2_ON, C1_ON, GAP.
  - IDLE: if hold=0 and any count is nonzero, select by priority soda > c2 > c1.
  - On selection, decrement the selected counter, load timer=PULSE_W−1 and enter the matching _ON state.
  - _ON: the matching output is 1. Timer counts down; at 0, load timer=GAP_W−1 and go to GAP.
  - GAP: all outputs are 0. At timer 0, go to IDLE.
  - hold is ignored in _ON and GAP: a pulse in progress always completes.
- Outputs are Moore, decoded from the registered state. At most one actuator output is high at any time.
- Latency:
  - A request sampled at edge k increments its counter at edge k.
  - If the FSM is IDLE with hold=0, the output rises after edge k+1, i.e. 1 cycle after the counter updates.
  - Back-to-back pulses are spaced PULSE_W+GAP_W+1 cycles apart, start to start, because of the one IDLE cycle between them.
- busy is combinational: (state≠IDLE) | (|cnt_soda) | (|cnt_c1) | (|cnt_c2).
- Input pulses wider than 1 cycle count once per cycle high. No edge detection is performed; this is intended.

Decomposition:
- Shared package dispenser_pkg holds:
  - FSM state encoding localparams;
  - default PULSE_W, GAP_W, CNT_W;
  - timer width derived as $clog2(max(PULSE_W,GAP_W)).
- One sub-module, pend_counter, instantiated 3 times.
  - Inputs: inc amount (0..3), dec (1 bit), clr.
  - Outputs: count, nonzero, sat_hit.
- Top level OR-reduces sat_hit into overflow and contains the FSM and timer.

Test Plan:
1. rst=1 mid-sim with no traffic → all outputs 0 and busy=0. Release rst and idle 10 cycles → outputs remain 0.
2. One soda pulse at edge k, hold=0 → soda_drop high for exactly 4 cycles starting after edge k+1, then 2 low cycles. busy falls after the GAP ends. eject1 and eject2 never assert.
3. soda and out2x2 in the same cycle → sequence soda_drop, eject2, eject2. Each pulse is 4 cycles; pulse starts are 7 cycles apart. Finally cnt_c2=0 and busy=0.
4. hold=1, then 8 consecutive out1 cycles → cnt_c1=7 and overflow=1 after the 8th. Drop hold → exactly 7 eject1 pulses; overflow stays 1. Pulse clr_err → overflow=0.
5. rst asserted asynchronously while eject2 is high with cnt_c2=2 → eject2 falls without waiting for a clock edge. After release, no eject2 pulses appear.
6. cnt_c1=1; out1 arrives in the same cycle the FSM leaves IDLE for C1_ON → count stays 1 and exactly 2 eject1 pulses are produced in total.
